ks_sub_pipe: RTL and testbench

KS_SUB_PIPE -- requirements
Module: ks_sub_pipe

---
 rtl/ks_pkg.sv | 33 +++
 rtl/ks_prefix_level.sv | 29 ++
 rtl/ks_sub_pipe.sv | 140 ++++++++++++++
 tb/tb_ks_sub_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared widths, stage payload types and operand preparation for the
// pipelined Kogge-Stone add/subtract unit.
package ks_pkg;

    localparam int KS_W         = 32;
    localparam int KS_LEVELS    = 5;
    localparam int KS_S1_LEVELS = 2;
    localparam int KS_TAG_MAX   = 8;

    // p is the raw per-bit propagate used for the final sum; g/pk are the
    // prefix group generate/propagate after the levels completed so far.
    typedef struct packed {
        logic [KS_W-1:0]       p;
        logic [KS_W-1:0]       g;
        logic [KS_W-1:0]       pk;
        logic [KS_TAG_MAX-1:0] tag;
        logic                  sub;
    } ks_s1_t;

    typedef struct packed {
        logic [KS_W-1:0]       p;
        logic [KS_W-1:0]       g;
        logic [KS_W-1:0]       pk;
        logic [KS_TAG_MAX-1:0] tag;
        logic                  sub;
    } ks_s2_t;

    function automatic logic [KS_W-1:0] ks_prep_b(input logic [KS_W-1:0] b,
                                                   input logic            sub);
        return sub ? ~b : b;
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level: pass-through below SPAN,
// grey cells where the lower group is already complete, black cells above.
module ks_prefix_level
    import ks_pkg::*;
#(
    parameter int SPAN = 1
) (
    input  logic [KS_W-1:0] g_i,
    input  logic [KS_W-1:0] p_i,
    output logic [KS_W-1:0] g_o,
    output logic [KS_W-1:0] p_o
);

    genvar gi;
    for (gi = 0; gi < KS_W; gi++) begin : g_cell
        if (gi < SPAN) begin : g_pass
            assign g_o[gi] = g_i[gi];
            assign p_o[gi] = p_i[gi];
        end else if (gi < 2 * SPAN) begin : g_grey
            // Group propagate here is never consumed by a later level.
            assign g_o[gi] = g_i[gi] | (p_i[gi] & g_i[gi-SPAN]);
            assign p_o[gi] = p_i[gi];
        end else begin : g_black
            assign g_o[gi] = g_i[gi] | (p_i[gi] & g_i[gi-SPAN]);
            assign p_o[gi] = p_i[gi] & p_i[gi-SPAN];
        end
    end

endmodule

// File: rtl/ks_sub_pipe.sv
// Three-stage valid/ready Kogge-Stone 32-bit add/subtract with tag sideband.
// Define KS_SUB_OVF_EN to add the pipelined signed-overflow output o_ovf.
module ks_sub_pipe
    import ks_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [KS_W-1:0]  i_a,
    input  logic [KS_W-1:0]  i_b,
    input  logic             i_sub,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [KS_W-1:0]  o_res,
    output logic             o_borrow,
    output logic [TAG_W-1:0] o_tag
`ifdef KS_SUB_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    genvar gi;

    // Operand preparation; carry-in folds into bit 0 as a generate term.
    logic [KS_W-1:0] b_prep;
    logic [KS_W-1:0] p0;
    logic [KS_W-1:0] g0;
    assign b_prep = ks_prep_b(i_b, i_sub);
    assign p0     = i_a ^ b_prep;
    assign g0     = (i_a & b_prep) | {{(KS_W-1){1'b0}}, p0[0] & i_sub};

    logic [KS_W-1:0] ga [KS_S1_LEVELS+1];
    logic [KS_W-1:0] pa [KS_S1_LEVELS+1];
    assign ga[0] = g0;
    assign pa[0] = p0;
    for (gi = 0; gi < KS_S1_LEVELS; gi++) begin : g_lvl_a
        ks_prefix_level #(.SPAN(1 << gi)) u_lvl (
            .g_i(ga[gi]), .p_i(pa[gi]), .g_o(ga[gi+1]), .p_o(pa[gi+1])
        );
    end

    ks_s1_t s1_d, s1_q;
    logic   s1_v_q;
    assign s1_d = '{p: p0, g: ga[KS_S1_LEVELS], pk: pa[KS_S1_LEVELS],
                    tag: KS_TAG_MAX'(i_tag), sub: i_sub};

    localparam int S2_LEVELS = KS_LEVELS - KS_S1_LEVELS;
    logic [KS_W-1:0] gb [S2_LEVELS+1];
    logic [KS_W-1:0] pb [S2_LEVELS+1];
    assign gb[0] = s1_q.g;
    assign pb[0] = s1_q.pk;
    for (gi = 0; gi < S2_LEVELS; gi++) begin : g_lvl_b
        ks_prefix_level #(.SPAN(1 << (gi + KS_S1_LEVELS))) u_lvl (
            .g_i(gb[gi]), .p_i(pb[gi]), .g_o(gb[gi+1]), .p_o(pb[gi+1])
        );
    end

    ks_s2_t s2_d, s2_q;
    logic   s2_v_q;
    assign s2_d = '{p: s1_q.p, g: gb[S2_LEVELS], pk: pb[S2_LEVELS],
                    tag: s1_q.tag, sub: s1_q.sub};

    // g[i] of the completed prefix is the carry out of bit i.
    logic [KS_W-1:0]       s3_res_d, s3_res_q;
    logic                  s3_borrow_d, s3_borrow_q;
    logic [KS_TAG_MAX-1:0] s3_tag_q;
    logic                  s3_v_q;
    assign s3_res_d    = s2_q.p ^ {s2_q.g[KS_W-2:0], s2_q.sub};
    assign s3_borrow_d = s2_q.g[KS_W-1] ^ s2_q.sub;

    // A stage may load when empty or when the stage after it also loads.
    logic s1_en, s2_en, s3_en;
    assign s3_en   = ~s3_v_q | i_ready;
    assign s2_en   = ~s2_v_q | s3_en;
    assign s1_en   = ~s1_v_q | s2_en;
    assign o_ready = s1_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_v_q <= 1'b0;
            s1_q   <= '0;
        end else if (s1_en) begin
            s1_v_q <= i_valid;
            if (i_valid) s1_q <= s1_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_v_q <= 1'b0;
            s2_q   <= '0;
        end else if (s2_en) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) s2_q <= s2_d;
        end
    end

`ifdef KS_SUB_OVF_EN
    logic s3_ovf_d, s3_ovf_q;
    assign s3_ovf_d = s2_q.g[KS_W-1] ^ s2_q.g[KS_W-2];
    assign o_ovf    = s3_ovf_q;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s3_v_q      <= 1'b0;
            s3_res_q    <= '0;
            s3_borrow_q <= 1'b0;
            s3_tag_q    <= '0;
`ifdef KS_SUB_OVF_EN
            s3_ovf_q    <= 1'b0;
`endif
        end else if (s3_en) begin
            s3_v_q <= s2_v_q;
            if (s2_v_q) begin
                s3_res_q    <= s3_res_d;
                s3_borrow_q <= s3_borrow_d;
                s3_tag_q    <= s2_q.tag;
`ifdef KS_SUB_OVF_EN
                s3_ovf_q    <= s3_ovf_d;
`endif
            end
        end
    end

    assign o_valid  = s3_v_q;
    assign o_res    = s3_res_q;
    assign o_borrow = s3_borrow_q;
    assign o_tag    = s3_tag_q[TAG_W-1:0];

    // Final group propagate and tag padding have no consumer.
    logic unused_bits;
    assign unused_bits = ^{s2_q.pk, s3_tag_q};

endmodule

// File: tb/tb_ks_sub_pipe.sv
// Scoreboard bench for ks_sub_pipe: directed vectors, stall burst, reset
// flush and randomized traffic against a plain-arithmetic reference model.
module tb_ks_sub_pipe;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [31:0]      i_a = '0;
    logic [31:0]      i_b = '0;
    logic             i_sub = 1'b0;
    logic [TAG_W-1:0] i_tag = '0;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic [31:0]      o_res;
    logic             o_borrow;
    logic [TAG_W-1:0] o_tag;
`ifdef KS_SUB_OVF_EN
    logic             o_ovf;
`endif

    ks_sub_pipe #(.TAG_W(TAG_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready), .o_res(o_res),
        .o_borrow(o_borrow), .o_tag(o_tag)
`ifdef KS_SUB_OVF_EN
        , .o_ovf(o_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      res;
        logic             borrow;
        logic [TAG_W-1:0] tag;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic [TAG_W-1:0] tag);
        exp_t   e;
        longint sa, sbv, sr;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (sub) begin
            e.res    = a - b;
            e.borrow = (a < b);
            sr       = sa - sbv;
        end else begin
            {e.borrow, e.res} = {1'b0, a} + {1'b0, b};
            sr = sa + sbv;
        end
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.tag = tag;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: occupancy-based ready check, hold check, pop/compare, push.
    logic              stall_q = 1'b0;
    logic [TAG_W+33:0] hold_q = '0;
    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (!rst_n) begin
            sb.delete();
            stall_q = 1'b0;
        end else begin
            checks++;
            if (o_ready !== ((sb.size() < 3) || i_ready)) begin
                errors++;
                $display("FAIL ready: got %0b occupancy %0d i_ready %0b", o_ready, sb.size(), i_ready);
            end
            if (stall_q) begin
                checks++;
                if ({o_valid, o_res, o_borrow, o_tag} !== hold_q) begin
                    errors++;
                    $display("FAIL hold: got 0x%h expected 0x%h", {o_valid, o_res, o_borrow, o_tag}, hold_q);
                end
            end
            stall_q = o_valid && !i_ready;
            hold_q  = {o_valid, o_res, o_borrow, o_tag};
            if (o_valid && i_ready) begin
                checks++;
                n_out++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got res 0x%08h tag %0d expected no output", o_res, o_tag);
                end else begin
                    e  = sb.pop_front();
                    ok = (o_res === e.res) && (o_borrow === e.borrow) && (o_tag === e.tag);
`ifdef KS_SUB_OVF_EN
                    ok = ok && (o_ovf === e.ovf);
`endif
                    if (!ok) begin
                        errors++;
                        $display("FAIL result: got res 0x%08h brw %0b tag %0d expected res 0x%08h brw %0b tag %0d ovf %0b",
                                 o_res, o_borrow, o_tag, e.res, e.borrow, e.tag, e.ovf);
                    end else begin
                        $display("out %0d: res 0x%08h brw %0b tag %0d", n_out, o_res, o_borrow, o_tag);
                    end
                end
            end
            if (i_valid && o_ready) sb.push_back(model(i_a, i_b, i_sub, i_tag));
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Called at posedge+1 with an empty pipe; checks latency and result.
    task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic sub,
                            input logic [TAG_W-1:0] tag, input logic [31:0] er,
                            input logic eb, input logic eo);
        int lat;
        i_ready = 1'b1;
        i_a = a; i_b = b; i_sub = sub; i_tag = tag; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 3);
        chk("dir_res", o_res, er);
        chk("dir_borrow", {31'b0, o_borrow}, {31'b0, eb});
        chk("dir_tag", {28'b0, o_tag}, {28'b0, tag});
`ifdef KS_SUB_OVF_EN
        chk("dir_ovf", {31'b0, o_ovf}, {31'b0, eo});
`else
        if (eo) $display("note: overflow expectation not observable in this build");
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        int  sent;
        int  cyc;
        int  out0;
        logic took;
        logic saw_full;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_res", o_res, 32'd0);
        chk("rst_borrow", {31'b0, o_borrow}, 32'd0);
        chk("rst_tag", {28'b0, o_tag}, 32'd0);
`ifdef KS_SUB_OVF_EN
        chk("rst_ovf", {31'b0, o_ovf}, 32'd0);
`endif
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", {31'b0, o_ready}, 32'd1);

        directed(32'h5, 32'h3, 1'b1, 4'd2, 32'h2, 1'b0, 1'b0);
        directed(32'h0, 32'h1, 1'b1, 4'd3, 32'hFFFF_FFFF, 1'b1, 1'b0);
        directed(32'h8000_0000, 32'h1, 1'b1, 4'd4, 32'h7FFF_FFFF, 1'b0, 1'b1);
        directed(32'hFFFF_FFFF, 32'h1, 1'b0, 4'd5, 32'h0, 1'b1, 1'b0);

        // Burst of 10 with output stalled for cycles 4..8.
        sent = 0; took = 1'b1; saw_full = 1'b0; out0 = n_out;
        for (int c = 0; c < 60 && (sent < 10 || sb.size() > 0); c++) begin
            i_ready = !(c >= 4 && c <= 8);
            if (sent < 10) begin
                if (took) begin
                    i_a = $urandom; i_b = $urandom; i_sub = 1'($urandom_range(0, 1));
                    i_tag = TAG_W'(sent);
                end
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            took = i_valid && o_ready;
            if (i_valid && !o_ready) saw_full = 1'b1;
            @(posedge clk); #1;
            if (took) sent++;
        end
        i_valid = 1'b0;
        chk("burst_full_seen", {31'b0, saw_full}, 32'd1);
        chk("burst_count", n_out - out0, 32'd10);

        // Reset with results in flight.
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_a = $urandom; i_b = $urandom; i_sub = 1'b1; i_tag = TAG_W'(k + 8);
            i_valid = 1'b1;
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        chk("pre_rst_valid", {31'b0, o_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, o_valid}, 32'd0);
        chk("async_rst_res", o_res, 32'd0);
        chk("async_rst_tag", {28'b0, o_tag}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        i_ready = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst2", {31'b0, o_ready}, 32'd1);
        out0 = n_out;
        repeat (6) @(posedge clk);
        #1;
        chk("no_stale", n_out - out0, 32'd0);
        directed(32'h1234_5678, 32'h0000_0078, 1'b1, 4'd7, 32'h1234_5600, 1'b0, 1'b0);

        // Randomized traffic with random back-pressure.
        sent = 0; cyc = 0; took = 1'b0; i_valid = 1'b0;
        while (sent < 300 && cyc < 5000) begin
            if (!i_valid || took) begin
                if ($urandom_range(0, 4) != 0) begin
                    i_valid = 1'b1;
                    i_a = pick(); i_b = pick();
                    i_sub = 1'($urandom_range(0, 1)); i_tag = TAG_W'($urandom);
                end else begin
                    i_valid = 1'b0;
                end
            end
            i_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = i_valid && o_ready;
            @(posedge clk); #1;
            if (took) sent++;
            cyc++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk("random_sent", sent, 32'd300);
        for (int k = 0; k < 200 && sb.size() > 0; k++) @(posedge clk);
        #1;
        chk("drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
